// File: rtl/imuldiv_muldiv_dispatch_pkg.sv
// rtl/imuldiv_muldiv_dispatch_pkg.sv - function codes, FSM states and decode helpers for the muldiv dispatcher
package imuldiv_muldiv_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  // Divider function encoding shared with the iterative divider's request message
  localparam logic DIVREQ_FN_SIGNED   = 1'b0;
  localparam logic DIVREQ_FN_UNSIGNED = 1'b1;

  function automatic logic fn_legal(input logic [2:0] fn);
    return fn <= FN_REMU;
  endfunction

  function automatic logic fn_is_div(input logic [2:0] fn);
    return fn != FN_MUL;
  endfunction

  function automatic logic fn_is_rem(input logic [2:0] fn);
    return (fn == FN_REM) || (fn == FN_REMU);
  endfunction

  function automatic logic div_fn_of(input logic [2:0] fn);
    return ((fn == FN_DIVU) || (fn == FN_REMU)) ? DIVREQ_FN_UNSIGNED : DIVREQ_FN_SIGNED;
  endfunction

endpackage

// File: rtl/imuldiv_muldiv_dispatch_ctrl.sv
// rtl/imuldiv_muldiv_dispatch_ctrl.sv - dispatch FSM and val/rdy steering between requester and the two iterative units
module imuldiv_muldiv_dispatch_ctrl
  import imuldiv_muldiv_dispatch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic muldivreq_val,
  input  logic req_legal,
  input  logic sel_div,
  input  logic mulreq_rdy,
  input  logic divreq_rdy,
  input  logic mulresp_val,
  input  logic divresp_val,
  input  logic muldivresp_rdy,
  output logic muldivreq_rdy,
  output logic mulreq_val,
  output logic divreq_val,
  output logic mulresp_rdy,
  output logic divresp_rdy,
  output logic muldivresp_val,
  output logic req_accept,
  output logic resp_capture,
  output logic resp_done
);

  state_e state, state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (muldivreq_val) state_next = req_legal ? ST_ISSUE : ST_RESP;
      ST_ISSUE: if (sel_div ? divreq_rdy : mulreq_rdy) state_next = ST_WAIT;
      ST_WAIT:  if (sel_div ? divresp_val : mulresp_val) state_next = ST_RESP;
      ST_RESP:  if (muldivresp_rdy) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // sel_div comes from the latched fn, so the unselected unit never sees val or rdy
  always_comb begin
    muldivreq_rdy  = (state == ST_IDLE);
    mulreq_val     = (state == ST_ISSUE) && !sel_div;
    divreq_val     = (state == ST_ISSUE) && sel_div;
    mulresp_rdy    = (state == ST_WAIT) && !sel_div;
    divresp_rdy    = (state == ST_WAIT) && sel_div;
    muldivresp_val = (state == ST_RESP);
    req_accept     = (state == ST_IDLE) && muldivreq_val;
    resp_capture   = (state == ST_WAIT) && (sel_div ? divresp_val : mulresp_val);
    resp_done      = (state == ST_RESP) && muldivresp_rdy;
  end

endmodule

// File: rtl/imuldiv_muldiv_dispatch.sv
// rtl/imuldiv_muldiv_dispatch.sv - single-outstanding muldiv scheduler: latches the request, dispatches to mul or div, formats and returns the result
module imuldiv_muldiv_dispatch
  import imuldiv_muldiv_dispatch_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       muldivreq_msg_fn,
  input  logic [31:0]      muldivreq_msg_a,
  input  logic [31:0]      muldivreq_msg_b,
  input  logic             muldivreq_val,
  output logic             muldivreq_rdy,
  output logic [63:0]      muldivresp_msg_result,
  output logic             muldivresp_val,
  input  logic             muldivresp_rdy,
  output logic [31:0]      mulreq_msg_a,
  output logic [31:0]      mulreq_msg_b,
  output logic             mulreq_val,
  input  logic             mulreq_rdy,
  input  logic [63:0]      mulresp_msg_result,
  input  logic             mulresp_val,
  output logic             mulresp_rdy,
  output logic             divreq_msg_fn,
  output logic [31:0]      divreq_msg_a,
  output logic [31:0]      divreq_msg_b,
  output logic             divreq_val,
  input  logic             divreq_rdy,
  input  logic [63:0]      divresp_msg_result,
  input  logic             divresp_val,
  output logic             divresp_rdy,
  output logic [CNT_W-1:0] op_count
);

  logic [2:0]  fn_reg;
  logic [31:0] a_reg, b_reg;
  logic [63:0] result_reg;
  logic [63:0] unit_result, formatted;
  logic        sel_div, req_accept, resp_capture, resp_done;

  assign sel_div = fn_is_div(fn_reg);

  imuldiv_muldiv_dispatch_ctrl u_ctrl (
    .clk            (clk),
    .reset          (reset),
    .muldivreq_val  (muldivreq_val),
    .req_legal      (fn_legal(muldivreq_msg_fn)),
    .sel_div        (sel_div),
    .mulreq_rdy     (mulreq_rdy),
    .divreq_rdy     (divreq_rdy),
    .mulresp_val    (mulresp_val),
    .divresp_val    (divresp_val),
    .muldivresp_rdy (muldivresp_rdy),
    .muldivreq_rdy  (muldivreq_rdy),
    .mulreq_val     (mulreq_val),
    .divreq_val     (divreq_val),
    .mulresp_rdy    (mulresp_rdy),
    .divresp_rdy    (divresp_rdy),
    .muldivresp_val (muldivresp_val),
    .req_accept     (req_accept),
    .resp_capture   (resp_capture),
    .resp_done      (resp_done)
  );

  // Remainder ops swap halves so the architectural result always sits in the low word
  always_comb begin
    unit_result = sel_div ? divresp_msg_result : mulresp_msg_result;
    formatted   = fn_is_rem(fn_reg) ? {unit_result[31:0], unit_result[63:32]} : unit_result;
  end

  // Clearing the result on accept leaves an illegal fn answering with zero
  always_ff @(posedge clk) begin
    if (reset) begin
      fn_reg     <= FN_MUL;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      op_count   <= '0;
    end else begin
      if (req_accept) begin
        fn_reg     <= muldivreq_msg_fn;
        a_reg      <= muldivreq_msg_a;
        b_reg      <= muldivreq_msg_b;
        result_reg <= '0;
      end
      if (resp_capture) result_reg <= formatted;
      if (resp_done)    op_count   <= op_count + CNT_W'(1);
    end
  end

  assign mulreq_msg_a          = a_reg;
  assign mulreq_msg_b          = b_reg;
  assign divreq_msg_a          = a_reg;
  assign divreq_msg_b          = b_reg;
  assign divreq_msg_fn         = div_fn_of(fn_reg);
  assign muldivresp_msg_result = result_reg;

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
// tb/tb_imuldiv_muldiv_dispatch.sv - scoreboard bench with behavioural mul/div units and an arithmetic reference model
module tb_imuldiv_muldiv_dispatch;
  import imuldiv_muldiv_dispatch_pkg::*;

  localparam int CNT_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic [2:0]       muldivreq_msg_fn = '0;
  logic [31:0]      muldivreq_msg_a = '0, muldivreq_msg_b = '0;
  logic             muldivreq_val = 1'b0;
  logic             muldivreq_rdy;
  logic [63:0]      muldivresp_msg_result;
  logic             muldivresp_val;
  logic             muldivresp_rdy = 1'b0;
  logic [31:0]      mulreq_msg_a, mulreq_msg_b;
  logic             mulreq_val;
  logic             mulreq_rdy = 1'b0;
  logic [63:0]      mulresp_msg_result = '0;
  logic             mulresp_val = 1'b0;
  logic             mulresp_rdy;
  logic             divreq_msg_fn;
  logic [31:0]      divreq_msg_a, divreq_msg_b;
  logic             divreq_val;
  logic             divreq_rdy = 1'b0;
  logic [63:0]      divresp_msg_result = '0;
  logic             divresp_val = 1'b0;
  logic             divresp_rdy;
  logic [CNT_W-1:0] op_count;

  imuldiv_muldiv_dispatch #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a), .muldivreq_msg_b(muldivreq_msg_b),
    .muldivreq_val(muldivreq_val), .muldivreq_rdy(muldivreq_rdy),
    .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_val(muldivresp_val), .muldivresp_rdy(muldivresp_rdy),
    .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b), .mulreq_val(mulreq_val), .mulreq_rdy(mulreq_rdy),
    .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val), .mulresp_rdy(mulresp_rdy),
    .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
    .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
    .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val), .divresp_rdy(divresp_rdy),
    .op_count(op_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // Architectural result: MUL full signed product, DIV/DIVU {rem,quot}, REM/REMU rem in the low word
  function automatic logic [63:0] ref_result(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    q = '0;
    r = '0;
    case (fn)
      3'd0: return 64'(sa * sb);
      3'd1, 3'd3: begin q = 32'(sa / sb); r = 32'(sa % sb); end
      3'd2, 3'd4: begin q = 32'(ua / ub); r = 32'(ua % ub); end
      default: return 64'd0;
    endcase
    if (fn == 3'd1 || fn == 3'd2) return {r, q};
    return {q, r};
  endfunction

  // Behavioural iterative divider: {rem, quot}, signedness from its own fn bit
  function automatic logic [63:0] div_unit(input logic uns, input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    x = uns ? longint'({32'b0, a}) : longint'($signed(a));
    y = uns ? longint'({32'b0, b}) : longint'($signed(b));
    return {32'(x % y), 32'(x / y)};
  endfunction

  logic [63:0] exp_q[$];
  logic [2:0]  cur_fn = '0;
  logic [31:0] cur_a = '0, cur_b = '0;
  int unit_rdy_pct = 100;
  int lat_min = 0, lat_max = 0;
  bit resp_rdy_rand = 1'b0;
  logic resp_rdy_fix = 1'b1;
  int done_cnt = 0;
  int mul_seen = 0, div_seen = 0;
  logic last_div_fn = 1'b0;

  always begin
    @(posedge clk);
    #1;
    muldivresp_rdy = resp_rdy_rand ? 1'($urandom_range(0, 1)) : resp_rdy_fix;
  end

  always @(negedge clk) begin
    if (mulreq_val) mul_seen++;
    if (divreq_val) begin div_seen++; last_div_fn = divreq_msg_fn; end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && muldivresp_val && muldivresp_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=%h expected=none", muldivresp_msg_result);
      end else begin
        check("resp_result", muldivresp_msg_result, exp_q.pop_front());
      end
      done_cnt++;
    end
  end

  bit m_busy = 0, d_busy = 0;
  int m_lat = 0, d_lat = 0;
  logic [63:0] m_res = '0, d_res = '0;

  always begin : mul_unit
    logic fire, done;
    logic [31:0] oa, ob;
    @(negedge clk);
    fire = mulreq_val && mulreq_rdy && !reset;
    done = mulresp_val && mulresp_rdy;
    oa = mulreq_msg_a;
    ob = mulreq_msg_b;
    if (fire) begin
      check("mul_selected", {61'b0, cur_fn}, {61'b0, FN_MUL});
      check("mul_operands", {oa, ob}, {cur_a, cur_b});
    end
    @(posedge clk);
    #1;
    if (reset) begin
      m_busy = 0;
      mulresp_val = 1'b0;
    end else begin
      if (done) begin m_busy = 0; mulresp_val = 1'b0; end
      if (fire) begin
        m_busy = 1;
        m_lat = $urandom_range(lat_min, lat_max);
        m_res = 64'(longint'($signed(oa)) * longint'($signed(ob)));
      end
      if (m_busy && !mulresp_val) begin
        if (m_lat == 0) mulresp_val = 1'b1;
        else m_lat--;
      end
    end
    mulreq_rdy = !m_busy && ($urandom_range(1, 100) <= unit_rdy_pct);
    mulresp_msg_result = mulresp_val ? m_res : {$urandom, $urandom};
  end

  always begin : div_unit_proc
    logic fire, done, uns;
    logic [31:0] oa, ob;
    @(negedge clk);
    fire = divreq_val && divreq_rdy && !reset;
    done = divresp_val && divresp_rdy;
    oa = divreq_msg_a;
    ob = divreq_msg_b;
    uns = divreq_msg_fn;
    if (fire) begin
      check("div_selected", {63'b0, fn_legal(cur_fn) && cur_fn != FN_MUL}, 64'd1);
      check("div_operands", {oa, ob}, {cur_a, cur_b});
    end
    @(posedge clk);
    #1;
    if (reset) begin
      d_busy = 0;
      divresp_val = 1'b0;
    end else begin
      if (done) begin d_busy = 0; divresp_val = 1'b0; end
      if (fire) begin
        d_busy = 1;
        d_lat = $urandom_range(lat_min, lat_max);
        d_res = div_unit(uns, oa, ob);
      end
      if (d_busy && !divresp_val) begin
        if (d_lat == 0) divresp_val = 1'b1;
        else d_lat--;
      end
    end
    divreq_rdy = !d_busy && ($urandom_range(1, 100) <= unit_rdy_pct);
    divresp_msg_result = divresp_val ? d_res : {$urandom, $urandom};
  end

  // Returns just after the accepting edge
  task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(posedge clk);
    #1;
    muldivreq_msg_fn = fn;
    muldivreq_msg_a = a;
    muldivreq_msg_b = b;
    muldivreq_val = 1'b1;
    forever begin
      @(negedge clk);
      if (muldivreq_rdy) break;
      n++;
      if (n > 500) begin fail_now("req_accept"); break; end
    end
    cur_fn = fn;
    cur_a = a;
    cur_b = b;
    exp_q.push_back(ref_result(fn, a, b));
    @(posedge clk);
    #1;
    muldivreq_val = 1'b0;
    muldivreq_msg_fn = 3'($urandom);
    muldivreq_msg_a = $urandom;
    muldivreq_msg_b = $urandom;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt != target) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin fail_now("resp_done"); break; end
    end
  endtask

  task automatic count_to_val(input string name, input int exp_cycles);
    int n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (muldivresp_val || n > 50) break;
    end
    check(name, 64'(n), 64'(exp_cycles));
  endtask

  initial begin
    int base, issued, snap_cnt;
    logic [63:0] snap_res;
    logic [2:0] fn;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_handshake", {60'b0, muldivreq_rdy, muldivresp_val, mulreq_val, divreq_val}, 64'h8);
    check("rst_unit_rdy", {62'b0, mulresp_rdy, divresp_rdy}, 64'd0);
    check("rst_result", muldivresp_msg_result, 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    check("rst_operands", {mulreq_msg_a, mulreq_msg_b} | {divreq_msg_a, divreq_msg_b}, 64'd0);

    // MUL 7 * -3 with minimum latency
    resp_rdy_fix = 1'b0;
    base = div_seen;
    issue(FN_MUL, 32'd7, 32'hFFFFFFFD);
    count_to_val("mul_latency", 3);
    resp_rdy_fix = 1'b1;
    wait_done(1);
    check("mul_no_div_val", 64'(div_seen - base), 64'd0);
    check("mul_op_count", 64'(op_count), 64'd1);

    issue(FN_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(2);
    check("div_fn_signed", {63'b0, last_div_fn}, {63'b0, DIVREQ_FN_SIGNED});

    issue(FN_REMU, 32'd7, 32'd2);
    wait_done(3);
    check("remu_fn_unsigned", {63'b0, last_div_fn}, {63'b0, DIVREQ_FN_UNSIGNED});

    // Illegal function answers with zero one cycle after accept
    resp_rdy_fix = 1'b0;
    base = mul_seen + div_seen;
    issue(3'd6, $urandom, $urandom);
    count_to_val("illegal_latency", 1);
    resp_rdy_fix = 1'b1;
    wait_done(4);
    check("illegal_no_unit_val", 64'(mul_seen + div_seen - base), 64'd0);

    // Response backpressure
    resp_rdy_fix = 1'b0;
    issue(FN_DIVU, 32'd1000, 32'd7);
    count_to_val("bp_reach_resp", 3);
    snap_res = muldivresp_msg_result;
    snap_cnt = int'(op_count);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {muldivresp_val, muldivreq_rdy, 62'(op_count), muldivresp_msg_result[31:0] ^ snap_res[31:0] | 32'(muldivresp_msg_result[63:32] ^ snap_res[63:32])},
            {1'b1, 1'b0, 62'(snap_cnt), 32'd0});
    end
    resp_rdy_fix = 1'b1;
    wait_done(5);
    check("bp_count", 64'(op_count), 64'((snap_cnt + 1) % 8));

    // Reset while the divider is working
    lat_min = 8;
    lat_max = 8;
    issue(FN_DIV, 32'd100, 32'd9);
    begin
      int n = 0;
      while (!divresp_rdy) begin
        @(negedge clk);
        n++;
        if (n > 50) begin fail_now("reach_wait"); break; end
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    lat_min = 0;
    lat_max = 0;
    @(negedge clk);
    check("rst_wait_handshake", {59'b0, muldivreq_rdy, mulreq_val, divreq_val, mulresp_rdy, divresp_rdy}, 64'h10);
    check("rst_wait_op_count", 64'(op_count), 64'd0);
    base = done_cnt;
    issue(FN_MUL, 32'd3, 32'd4);
    wait_done(base + 1);
    check("post_rst_count", 64'(op_count), 64'd1);
    issued = 1;

    // Randomised traffic with unit stalls, variable latency and response backpressure
    resp_rdy_rand = 1'b1;
    unit_rdy_pct = 60;
    lat_max = 4;
    for (int i = 0; i < 40; i++) begin
      fn = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom);
      if (b == 32'd0) b = 32'd1;
      issue(fn, a, b);
      issued++;
    end
    wait_done(base + issued);
    check("rand_op_count_wrap", 64'(op_count), 64'(issued % 8));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imuldiv_muldiv_dispatch.md
# imuldiv_muldiv_dispatch

Front-end scheduler for the iterative integer multiply/divide units. It accepts one muldiv request at a time and decodes the function. It issues the operands to either the iterative multiplier or the iterative divider over their val/rdy interfaces, collects that unit's response, formats it, and returns it to the requester. It sits between the PARC pipeline's muldiv port and the two iterative units, with one operation outstanding at a time.

## Interface
- CNT_W, default 32: width of the completed-operation counter.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- muldivreq_msg_fn  in  3  function: 0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU, 5-7 illegal.
- muldivreq_msg_a / muldivreq_msg_b  in  32 each  operands.
- muldivreq_val  in  1 / muldivreq_rdy  out  1  request handshake.
- muldivresp_msg_result  out  64  formatted result.
- muldivresp_val  out  1 / muldivresp_rdy  in  1  response handshake.
- mulreq_msg_a / mulreq_msg_b  out  32 each; mulreq_val out 1; mulreq_rdy in 1.
- mulresp_msg_result  in  64; mulresp_val in 1; mulresp_rdy out 1.
- divreq_msg_fn  out  1  (signed/unsigned, per the DivReqMsg encoding); divreq_msg_a / divreq_msg_b  out  32 each; divreq_val out 1; divreq_rdy in 1.
- divresp_msg_result  in  64  ({rem, quot}); divresp_val in 1; divresp_rdy out 1.
- op_count  out  CNT_W  completed responses since reset; wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - muldivreq_rdy=1.
  - When muldivreq_val=1, latch fn, a and b into registers and go to ISSUE.
  - If fn is illegal, go directly to RESP with result register = 64'b0.
- ISSUE:
  - Drive the selected unit's req_val=1, with operands taken from the latched registers.
  - MUL selects the multiplier; DIV, DIVU, REM and REMU select the divider.
  - divreq_msg_fn is signed for DIV and REM, unsigned for DIVU and REMU.
  - When the selected unit's req_rdy=1 in the same cycle, go to WAIT.
- WAIT:
  - Drive the selected unit's resp_rdy=1.
  - When its resp_val=1, capture the formatted result and go to RESP.
- Result formatting:
  - MUL: unit result unchanged.
  - DIV / DIVU: {rem, quot} unchanged.
  - REM / REMU: halves swapped to {quot, rem}, so that the low word is always the architectural result.
- RESP:
  - muldivresp_val=1, with the result held stable.
  - When muldivresp_rdy=1, increment op_count and go to IDLE.
- Unselected unit: its val and rdy outputs are 0 in every state.
- Outputs are driven from the latched registers only, never combinationally from muldivreq_msg_*.

## Timing
- Reset values:
  - State: IDLE.
  - muldivreq_rdy=1; muldivresp_val=0.
  - mulreq_val, divreq_val, mulresp_rdy, divresp_rdy: all 0.
  - muldivresp_msg_result=0; op_count=0.
  - Operand output buses: 0.
- Latency:
  - The request is accepted at cycle t; ISSUE runs at t+1.
  - The earliest RESP is t+3: unit req_rdy at t+1 and resp_val at t+2.
  - For an illegal fn, RESP occurs at t+1.
  - The iterative unit's latency adds 1:1.
- No overlap: muldivreq_rdy=0 in ISSUE, WAIT and RESP. Completing a response and accepting a new request cannot occur in the same cycle.
- Backpressure in any state: state, operands and result hold unchanged indefinitely.
- Reset asserted mid-operation: the in-flight operation is abandoned and all outputs take their reset values the next cycle. The iterative units share this reset, so no stale response arrives.
- op_count wraps from 2^CNT_W-1 to 0.

## Structure
- The function codes (MUL/DIV/DIVU/REM/REMU) are defined as `define constants in a shared imuldiv-MulDivReqMsg.v include, alongside the existing DivReqMsg definitions. Both this block and the benches include it.
- One sub-module is natural: imuldiv_MulDivDispatchCtrl, containing the FSM and the val/rdy decode.
- The top level holds the operand, fn and result registers, the formatting mux and op_count.

## Test plan
- MUL, a=7, b=0xFFFFFFFD → result 0xFFFFFFFF_FFFFFFEB; divreq_val stays 0 throughout; op_count=1.
- DIV, a=0xFFFFFFF9 (-7), b=2 → divreq_msg_fn is signed; result 0xFFFFFFFF_FFFFFFFD.
- REMU, a=7, b=2 → result 0x00000003_00000001; divreq_msg_fn is unsigned.
- Illegal fn=6 → muldivresp_val=1 one cycle after accept; result 0; mulreq_val and divreq_val never asserted.
- Backpressure: hold muldivresp_rdy=0 for 5 cycles in RESP → val and result stable and muldivreq_rdy=0 throughout; the count increments only on the final handshake.
- Reset in WAIT during a DIV → next cycle muldivreq_rdy=1, all val/rdy outputs 0, op_count=0. A following MUL 3×4 returns 0x00000000_0000000C.
